// File: rtl/seg_pkg.sv
// seg_pkg: scan FSM states and active-high seven-segment glyphs {g,f,e,d,c,b,a}
package seg_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] GLYPHS [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                         SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-high {g..a} glyph
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = GLYPHS[nibble];
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: N-digit multiplexed seven-segment scanner with blanking dead time and per-frame input snapshot
module seven_seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DWELL_CYCLES = 25000,
  parameter int BLANK_CYCLES = 64,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit EN_ACT_LOW   = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [4*N_DIGITS-1:0]       digits,
  input  logic [N_DIGITS-1:0]         dp_in,
  input  logic [N_DIGITS-1:0]         blank_mask,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic [N_DIGITS-1:0]         dig_en,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        frame_tick
);
  localparam int CW = $clog2(DWELL_CYCLES);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [6:0] SEG_DARK = {7{SEG_ACT_LOW}};
  localparam logic [N_DIGITS-1:0] EN_DARK = {N_DIGITS{EN_ACT_LOW}};

  if (BLANK_CYCLES >= DWELL_CYCLES || N_DIGITS < 2) begin : g_param_err
    $fatal(1, "seven_seg_scan_ctrl: need BLANK_CYCLES < DWELL_CYCLES and N_DIGITS >= 2");
  end

  scan_state_t state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [IW-1:0] idx, nidx;
  logic [4*N_DIGITS-1:0] digits_q;
  logic [N_DIGITS-1:0] dp_q, blank_q;
  logic [6:0] glyph;
  logic snap, lit;

  hex_to_seg7 u_dec (.nibble(digits_q[4*nidx +: 4]), .seg(glyph));

  // next slot position: dropping enable parks the scanner, otherwise step through BLANK/SHOW slots
  always_comb begin
    nstate = state;
    ncnt   = cnt + 1'b1;
    nidx   = idx;
    if (!enable) begin
      nstate = IDLE;
      ncnt   = '0;
      nidx   = '0;
    end else if (state == IDLE) begin
      nstate = BLANK;
      ncnt   = '0;
    end else if (state == BLANK && cnt == CW'(BLANK_CYCLES - 1)) begin
      nstate = SHOW;
    end else if (state == SHOW && cnt == CW'(DWELL_CYCLES - 1)) begin
      nstate = BLANK;
      ncnt   = '0;
      nidx   = idx == IW'(N_DIGITS - 1) ? '0 : idx + 1'b1;
    end
  end

  assign snap = nstate == BLANK && state != BLANK && nidx == '0;
  assign lit  = nstate == SHOW && !blank_q[nidx];
  assign digit_idx = idx;

  // state, counter and snapshot; outputs registered from the next state so they track it one clock later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      digits_q   <= '0;
      dp_q       <= '0;
      blank_q    <= '0;
      frame_tick <= 1'b0;
      seg        <= SEG_DARK;
      dp         <= SEG_ACT_LOW;
      dig_en     <= EN_DARK;
    end else begin
      state      <= nstate;
      cnt        <= ncnt;
      idx        <= nidx;
      frame_tick <= snap;
      if (snap) begin
        digits_q <= digits;
        dp_q     <= dp_in;
        blank_q  <= blank_mask;
      end
      seg    <= (lit ? glyph : SEG_OFF) ^ SEG_DARK;
      dp     <= (lit & dp_q[nidx]) ^ SEG_ACT_LOW;
      dig_en <= (nstate == SHOW ? N_DIGITS'(1) << nidx : '0) ^ EN_DARK;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed + random scan checks against a slot-arithmetic reference model
module tb_seven_seg_scan_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0] dp_in = '0;
  logic [3:0] blank_mask = '0;
  logic [6:0] seg;
  logic dp;
  logic [3:0] dig_en;
  logic [1:0] digit_idx;
  logic frame_tick;

  int total = 0;
  int bad = 0;

  bit m_run = 1'b0;
  int k = 0;
  logic [15:0] s_dig = '0;
  logic [3:0] s_dp = '0;
  logic [3:0] s_bl = '0;
  logic [6:0] hex_glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg_scan_ctrl #(
    .N_DIGITS(4), .DWELL_CYCLES(10), .BLANK_CYCLES(2), .SEG_ACT_LOW(1'b1), .EN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .digits(digits), .dp_in(dp_in),
    .blank_mask(blank_mask), .seg(seg), .dp(dp), .dig_en(dig_en), .digit_idx(digit_idx),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic chk(input string tag);
    logic [6:0] es;
    logic ed, et;
    logic [3:0] ee;
    int slot, pos, ei;
    es = 7'h7F; ed = 1'b1; ee = 4'hF; ei = 0; et = 1'b0;
    if (m_run) begin
      slot = (k / 10) % 4;
      pos  = k % 10;
      ei   = slot;
      et   = (k % 40) == 0;
      if (pos >= 2) begin
        ee = ~(4'b0001 << slot);
        if (!s_bl[slot]) begin
          es = ~hex_glyph[s_dig[slot*4 +: 4]];
          ed = ~s_dp[slot];
        end
      end
    end
    cmp({tag, ".seg"}, 32'(seg), 32'(es));
    cmp({tag, ".dp"}, 32'(dp), 32'(ed));
    cmp({tag, ".dig_en"}, 32'(dig_en), 32'(ee));
    cmp({tag, ".digit_idx"}, 32'(digit_idx), 32'(ei));
    cmp({tag, ".frame_tick"}, 32'(frame_tick), 32'(et));
  endtask

  // one clock: model follows the edge using the inputs it saw, then outputs are checked at the falling edge
  task automatic cyc(input string tag);
    @(posedge clk);
    if (!reset || !enable) begin
      m_run = 1'b0;
      k = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
      k = 0;
    end else begin
      k++;
    end
    if (m_run && k % 40 == 0) begin
      s_dig = digits;
      s_dp  = dp_in;
      s_bl  = blank_mask;
    end
    @(negedge clk);
    chk(tag);
  endtask

  task automatic run_to(input int phase, input string tag);
    for (int i = 0; i < 100 && !(m_run && k % 40 == phase); i++) cyc(tag);
  endtask

  initial begin
    enable = 1'b1;
    digits = 16'($urandom);
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc("reset");
    reset = 1'b1;
    digits = 16'h3210;
    for (int i = 0; i < 90; i++) cyc("scan");
    run_to(14, "scan");
    digits = 16'hFFFF;
    for (int i = 0; i < 80; i++) cyc("snapshot");
    blank_mask = 4'b0100;
    dp_in = 4'b0001;
    digits = 16'h9A5C;
    for (int i = 0; i < 85; i++) cyc("blank_dp");
    run_to(25, "pre_drop");
    enable = 1'b0;
    for (int i = 0; i < 4; i++) cyc("drop");
    enable = 1'b1;
    for (int i = 0; i < 45; i++) cyc("reenable");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 5) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 5) == 0) blank_mask = 4'($urandom);
      if (enable && $urandom_range(0, 60) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 2) == 0) enable = 1'b1;
      cyc("random");
    end
    enable = 1'b1;
    run_to(24, "pre_reset");
    #2;
    reset = 1'b0;
    #1;
    m_run = 1'b0;
    k = 0;
    chk("async_reset");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 45; i++) cyc("after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
